// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_add_sub
// Description : Pipelined two's-complement adder/subtractor, one carry slice
//               per stage, valid/ready handshake on both sides.
// Revision    : 1.0
// ============================================================================

module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  // Operands are only kept for stages that still feed a later slice.
  localparam int NP = (STAGES > 1) ? STAGES - 1 : 1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [NP];
  logic [WIDTH-1:0]  a_d   [NP];
  logic [WIDTH-1:0]  b_q   [NP];
  logic [WIDTH-1:0]  b_d   [NP];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic              advance;
  logic [WIDTH-1:0]  cur_a, cur_b, cur_s;
  logic              cur_c, cur_v;
  logic [SW:0]       slice;

  always_comb begin
    advance = !vld_q[STAGES-1] || out_ready;
    cur_a   = a;
    cur_b   = sub ? ~b : b;
    cur_c   = sub ? 1'b1 : c_in;
    cur_s   = '0;
    cur_v   = in_valid;
    vld_d   = '0;
    cy_d    = '0;
    slice   = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = '0;
    end
    for (int k = 0; k < NP; k++) begin
      a_d[k] = '0;
      b_d[k] = '0;
    end
    for (int k = 0; k < STAGES; k++) begin
      if (k > 0) begin
        cur_a = a_q[k-1];
        cur_b = b_q[k-1];
        cur_c = cy_q[k-1];
        cur_s = sum_q[k-1];
        cur_v = vld_q[k-1];
      end
      slice    = {1'b0, SW'(cur_a >> (k * SW))} + {1'b0, SW'(cur_b >> (k * SW))}
               + {{SW{1'b0}}, cur_c};
      sum_d[k] = cur_s | (WIDTH'(slice[SW-1:0]) << (k * SW));
      cy_d[k]  = slice[SW];
      vld_d[k] = cur_v;
      if (k < NP) begin
        a_d[k] = cur_a;
        b_d[k] = cur_b;
      end
    end
    // cur_a/cur_b now hold the final stage's operands (effective B).
    ovf_d  = (cur_a[WIDTH-1] == cur_b[WIDTH-1]) &&
             (sum_d[STAGES-1][WIDTH-1] != cur_a[WIDTH-1]);
    zero_d = (sum_d[STAGES-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
      for (int k = 0; k < NP; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q  <= vld_d;
      cy_q   <= cy_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
      end
      for (int k = 0; k < NP; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign c_out     = cy_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire
